// File: rtl/ras_pkg.sv
// Shared constants for the return-address stack: overflow policies and default geometry.
package ras_pkg;
    localparam int RAS_OVF_DROP  = 0;
    localparam int RAS_OVF_WRAP  = 1;
    localparam int RAS_WIDTH_DEF = 32;
    localparam int RAS_DEPTH_DEF = 32;
endpackage

// File: rtl/ras_regfile.sv
// Return-address storage: one synchronous write port, two asynchronous read ports.
module ras_regfile #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr_top,
    input  logic [AW-1:0]    raddr_pop,
    output logic [WIDTH-1:0] rdata_top,
    output logic [WIDTH-1:0] rdata_pop
);
    // Contents are deliberately left unreset; count gates every read that matters.
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata_top = mem[raddr_top];
    assign rdata_pop = mem[raddr_pop];
endmodule

// File: rtl/ret_addr_stack.sv
// Return-address stack: push link PC on call, pop it back on return, with status and sticky errors.
module ret_addr_stack
    import ras_pkg::*;
#(
    parameter int WIDTH    = RAS_WIDTH_DEF,
    parameter int DEPTH    = RAS_DEPTH_DEF,
    parameter int OVF_MODE = RAS_OVF_DROP,
    localparam int AW      = $clog2(DEPTH),
    localparam int CW      = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] pop_data,
    output logic             pop_valid,
    output logic [WIDTH-1:0] top_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic             underflow
);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [AW-1:0]    sp, sp_m1;
    logic             we;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] rd_top, rd_pop;

    assign sp_m1 = sp - 1'b1;
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign top_data = empty ? '0 : rd_top;

    // Push+pop on a non-empty stack replaces the top in place, so the write lands at sp-1.
    always_comb begin
        we    = 1'b0;
        waddr = sp;
        if (!reset && !flush && push) begin
            if (pop) begin
                if (!empty) begin
                    we    = 1'b1;
                    waddr = sp_m1;
                end
            end else if (!full || OVF_MODE == RAS_OVF_WRAP) begin
                we = 1'b1;
            end
        end
    end

    ras_regfile #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rf (
        .clk       (clk),
        .we        (we),
        .waddr     (waddr),
        .wdata     (push_data),
        .raddr_top (sp_m1),
        .raddr_pop (sp_m1),
        .rdata_top (rd_top),
        .rdata_pop (rd_pop)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            sp        <= '0;
            count     <= '0;
            pop_data  <= '0;
            pop_valid <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            pop_valid <= 1'b0;
            if (flush) begin
                sp    <= '0;
                count <= '0;
            end else begin
                case ({push, pop})
                    2'b10: begin
                        if (!full) begin
                            sp    <= sp + 1'b1;
                            count <= count + 1'b1;
                        end else begin
                            overflow <= 1'b1;
                            if (OVF_MODE == RAS_OVF_WRAP) sp <= sp + 1'b1;
                        end
                    end
                    2'b01: begin
                        if (!empty) begin
                            pop_data  <= rd_pop;
                            pop_valid <= 1'b1;
                            sp        <= sp_m1;
                            count     <= count - 1'b1;
                        end else begin
                            underflow <= 1'b1;
                        end
                    end
                    2'b11: begin
                        // Empty stack: the call's link goes straight through to the return.
                        pop_data  <= empty ? push_data : rd_pop;
                        pop_valid <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ret_addr_stack.sv
// Directed checks of ret_addr_stack: default geometry plus DEPTH=4 drop and wrap variants.
module tb_ret_addr_stack;
    logic        clk = 1'b0;
    logic        reset, push, pop, flush;
    logic [31:0] push_data;

    logic [31:0] a_pop_data, a_top;
    logic        a_pv, a_full, a_empty, a_ovf, a_unf;
    logic [5:0]  a_count;
    logic [31:0] b_pop_data, b_top;
    logic        b_pv, b_full, b_empty, b_ovf, b_unf;
    logic [2:0]  b_count;
    logic [31:0] c_pop_data, c_top;
    logic        c_pv, c_full, c_empty, c_ovf, c_unf;
    logic [2:0]  c_count;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ret_addr_stack u_a (
        .clk(clk), .reset(reset), .push(push), .pop(pop), .flush(flush), .push_data(push_data),
        .pop_data(a_pop_data), .pop_valid(a_pv), .top_data(a_top), .count(a_count),
        .full(a_full), .empty(a_empty), .overflow(a_ovf), .underflow(a_unf)
    );
    ret_addr_stack #(.WIDTH(32), .DEPTH(4), .OVF_MODE(0)) u_b (
        .clk(clk), .reset(reset), .push(push), .pop(pop), .flush(flush), .push_data(push_data),
        .pop_data(b_pop_data), .pop_valid(b_pv), .top_data(b_top), .count(b_count),
        .full(b_full), .empty(b_empty), .overflow(b_ovf), .underflow(b_unf)
    );
    ret_addr_stack #(.WIDTH(32), .DEPTH(4), .OVF_MODE(1)) u_c (
        .clk(clk), .reset(reset), .push(push), .pop(pop), .flush(flush), .push_data(push_data),
        .pop_data(c_pop_data), .pop_valid(c_pv), .top_data(c_top), .count(c_count),
        .full(c_full), .empty(c_empty), .overflow(c_ovf), .underflow(c_unf)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, sample 1 time unit after the edge, then return to idle.
    task automatic step(input logic rs, input logic pu, input logic po, input logic fl,
                        input logic [31:0] d);
        reset = rs; push = pu; pop = po; flush = fl; push_data = d;
        @(posedge clk);
        #1;
        reset = 1'b0; push = 1'b0; pop = 1'b0; flush = 1'b0; push_data = '0;
    endtask

    initial begin
        reset = 1'b0; push = 1'b0; pop = 1'b0; flush = 1'b0; push_data = '0;
        #2;
        step(1, 0, 0, 0, 0);
        chk("rst_count", 64'(a_count), 0);
        chk("rst_empty", 64'(a_empty), 1);
        chk("rst_full", 64'(a_full), 0);
        chk("rst_pv", 64'(a_pv), 0);
        chk("rst_pdata", 64'(a_pop_data), 0);
        chk("rst_flags", 64'({a_ovf, a_unf}), 0);
        chk("rst_top", 64'(a_top), 0);

        // LIFO order
        step(0, 1, 0, 0, 32'h100);
        step(0, 1, 0, 0, 32'h200);
        step(0, 1, 0, 0, 32'h300);
        chk("t1_count3", 64'(a_count), 3);
        chk("t1_top", 64'(a_top), 32'h300);
        step(0, 0, 1, 0, 0);
        chk("t1_pop1", 64'({a_pv, a_pop_data}), {1'b1, 32'h300});
        step(0, 0, 1, 0, 0);
        chk("t1_pop2", 64'({a_pv, a_pop_data}), {1'b1, 32'h200});
        chk("t1_count1", 64'(a_count), 1);
        step(0, 0, 1, 0, 0);
        chk("t1_pop3", 64'({a_pv, a_pop_data}), {1'b1, 32'h100});
        chk("t1_empty", 64'({a_count, a_empty}), {6'd0, 1'b1});
        step(0, 0, 0, 0, 0);
        chk("t1_pv_pulse", 64'(a_pv), 0);
        chk("t1_top_empty", 64'(a_top), 0);

        // Overflow: drop (b) vs wrap (c)
        step(1, 0, 0, 0, 0);
        for (int i = 1; i <= 5; i++) step(0, 1, 0, 0, 32'(i));
        chk("t2_b_count", 64'(b_count), 4);
        chk("t2_b_full", 64'(b_full), 1);
        chk("t2_b_ovf", 64'(b_ovf), 1);
        chk("t2_b_top", 64'(b_top), 4);
        step(0, 1, 0, 0, 32'd6);
        chk("t3_c_count", 64'(c_count), 4);
        chk("t3_c_ovf", 64'(c_ovf), 1);
        chk("t3_c_top", 64'(c_top), 6);
        chk("t3_a_count", 64'(a_count), 6);
        chk("t3_a_ovf", 64'(a_ovf), 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 1, 0, 0);
            chk("t2_b_pop", 64'({b_pv, b_pop_data}), {1'b1, 32'(4 - i)});
            chk("t3_c_pop", 64'({c_pv, c_pop_data}), {1'b1, 32'(6 - i)});
        end
        chk("t2_b_empty", 64'({b_count, b_empty, b_full}), {3'd0, 1'b1, 1'b0});
        chk("t3_c_empty", 64'({c_count, c_empty}), {3'd0, 1'b1});

        // Underflow and empty bypass
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 32'h55);
        step(0, 0, 1, 0, 0);
        chk("t4_pop55", 64'(a_pop_data), 32'h55);
        step(0, 0, 1, 0, 0);
        chk("t4_unf_pv", 64'(a_pv), 0);
        chk("t4_unf_hold", 64'(a_pop_data), 32'h55);
        chk("t4_unf_flag", 64'(a_unf), 1);
        chk("t4_unf_count", 64'(a_count), 0);
        step(0, 1, 1, 0, 32'hAB);
        chk("t4_byp", 64'({a_pv, a_pop_data}), {1'b1, 32'hAB});
        chk("t4_byp_count", 64'(a_count), 0);
        chk("t4_byp_ovf", 64'(a_ovf), 0);

        // Simultaneous push+pop replaces top
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 32'h10);
        step(0, 1, 0, 0, 32'h20);
        step(0, 1, 1, 0, 32'h30);
        chk("t5_pp_data", 64'({a_pv, a_pop_data}), {1'b1, 32'h20});
        chk("t5_pp_count", 64'(a_count), 2);
        chk("t5_pp_top", 64'(a_top), 32'h30);
        step(0, 0, 1, 0, 0);
        chk("t5_pop30", 64'(a_pop_data), 32'h30);
        step(0, 0, 1, 0, 0);
        chk("t5_pop10", 64'(a_pop_data), 32'h10);

        // Flush priority and reset during pop
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 32'h1);
        step(0, 1, 0, 0, 32'h2);
        step(0, 1, 0, 0, 32'h3);
        step(0, 1, 0, 1, 32'h4);
        chk("t6_fl_count", 64'({a_count, a_empty}), {6'd0, 1'b1});
        chk("t6_fl_top", 64'(a_top), 0);
        step(0, 0, 1, 0, 0);
        chk("t6_fl_unf", 64'(a_unf), 1);
        step(0, 1, 0, 0, 32'h7);
        step(0, 1, 0, 0, 32'h8);
        step(0, 0, 1, 0, 0);
        chk("t6_pop8", 64'(a_pop_data), 32'h8);
        step(1, 0, 1, 0, 0);
        chk("t6_rst_pv", 64'(a_pv), 0);
        chk("t6_rst_pdata", 64'(a_pop_data), 0);
        chk("t6_rst_flags", 64'({a_ovf, a_unf}), 0);
        chk("t6_rst_count", 64'(a_count), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
